// File: rtl/busy_window_scheduler_pkg.sv
// Shared parameters and helpers for the busy-window scheduler: window defaults
// and the clamped lo/hi bound computation used when a slot is loaded.
package busy_window_scheduler_pkg;

   localparam int MXHS_DEF    = 224;
   localparam int MXKEYBX_DEF = 8;
   localparam int NSLOT_DEF   = 4;

   typedef struct packed {
      logic [7:0] lo;
      logic [7:0] hi;
      logic [3:0] hold;
   } win_cfg_t;

   // Lower bound, floored at 0 and never above the last key.
   function automatic logic [7:0] win_lo(input logic [8:0] key,
                                         input logic [4:0] width,
                                         input logic [8:0] top_key);
      logic [8:0] lo_s;
      if ({4'b0000, width} > key) begin
         lo_s = 9'd0;
      end else begin
         lo_s = key - {4'b0000, width};
      end
      if (lo_s > top_key) begin
         lo_s = top_key;
      end else begin
         lo_s = lo_s;
      end
      return lo_s[7:0];
   endfunction

   function automatic logic [7:0] win_hi(input logic [8:0] key,
                                         input logic [4:0] width,
                                         input logic [8:0] top_key);
      logic [9:0] sum_s;
      logic [7:0] hi_s;
      sum_s = {1'b0, key} + {5'b00000, width};
      if (sum_s > {1'b0, top_key}) begin
         hi_s = top_key[7:0];
      end else begin
         hi_s = sum_s[7:0];
      end
      return hi_s;
   endfunction

endpackage

// File: rtl/busy_window_scheduler_slot.sv
// One busy window: latched bounds and countdown, plus the per-key range
// compare that turns the window into an MXHS-bit busy mask.
module busy_window_slot
   import busy_window_scheduler_pkg::*;
#(
   parameter int MXHS = MXHS_DEF
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            flush,
   input  logic            load,
   input  win_cfg_t        load_cfg,
   output logic            active,
   output logic            expiring,
   output logic            active_nxt,
   output logic [MXHS-1:0] mask
);

   logic       active_r;
   logic [3:0] cnt_r;
   logic [7:0] lo_r;
   logic [7:0] hi_r;
   logic       active_nxt_s;
   logic [3:0] cnt_nxt_s;
   logic [7:0] lo_nxt_s;
   logic [7:0] hi_nxt_s;

   // Next slot state: flush wins, a load overrides expiry, else count down.
   always_comb begin
      active_nxt_s = active_r;
      cnt_nxt_s    = cnt_r;
      lo_nxt_s     = lo_r;
      hi_nxt_s     = hi_r;
      if (flush) begin
         active_nxt_s = 1'b0;
         cnt_nxt_s    = 4'd0;
      end else if (load) begin
         active_nxt_s = 1'b1;
         cnt_nxt_s    = load_cfg.hold;
         lo_nxt_s     = load_cfg.lo;
         hi_nxt_s     = load_cfg.hi;
      end else if (active_r) begin
         cnt_nxt_s = cnt_r - 4'd1;
         if (cnt_r == 4'd1) begin
            active_nxt_s = 1'b0;
         end else begin
            active_nxt_s = 1'b1;
         end
      end else begin
         cnt_nxt_s = 4'd0;
      end
   end

   // Slot state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         active_r <= 1'b0;
         cnt_r    <= 4'd0;
         lo_r     <= 8'd0;
         hi_r     <= 8'd0;
      end else begin
         active_r <= active_nxt_s;
         cnt_r    <= cnt_nxt_s;
         lo_r     <= lo_nxt_s;
         hi_r     <= hi_nxt_s;
      end
   end

   // Range compare of every key against the latched window.
   always_comb begin
      mask = '0;
      for (int k = 0; k < MXHS; k++) begin
         if (active_r && (9'(k) >= {1'b0, lo_r}) && (9'(k) <= {1'b0, hi_r})) begin
            mask[k] = 1'b1;
         end else begin
            mask[k] = 1'b0;
         end
      end
   end

   assign active     = active_r;
   assign expiring   = active_r && (cnt_r == 4'd1);
   assign active_nxt = active_nxt_s;

endmodule

// File: rtl/busy_window_scheduler.sv
// Busy-window scheduler: places up to two candidate keys per clock into free
// slots and publishes the registered OR of all windows as per-key busy flags.
module busy_window_scheduler
   import busy_window_scheduler_pkg::*;
#(
   parameter int MXHS    = MXHS_DEF,
   parameter int MXKEYBX = MXKEYBX_DEF,
   parameter int NSLOT   = NSLOT_DEF
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               cfg_en,
   input  logic [4:0]         cfg_width,
   input  logic [3:0]         cfg_hold,
   input  logic               flush,
   input  logic               clct0_vld,
   input  logic [MXKEYBX-1:0] clct0_key,
   input  logic               clct1_vld,
   input  logic [MXKEYBX-1:0] clct1_key,
   output logic [MXHS-1:0]    bsy_hs,
   output logic [2:0]         nslot_busy,
   output logic               all_busy,
   output logic               ovf,
   output logic [7:0]         ovf_cnt
);

   localparam logic [8:0] TOP_KEY = 9'(MXHS - 1);

   logic [NSLOT-1:0] active_s;
   logic [NSLOT-1:0] expiring_s;
   logic [NSLOT-1:0] active_nxt_s;
   logic [NSLOT-1:0] free_s;
   logic [NSLOT-1:0] load_s;
   logic [MXHS-1:0]  mask_s [NSLOT];
   win_cfg_t         load_cfg_s [NSLOT];
   win_cfg_t         cfg0_s;
   win_cfg_t         cfg1_s;
   logic             alloc_ok_s;
   logic             req0_s;
   logic             req1_s;
   logic             taken0_s;
   logic             taken1_s;
   logic             drop0_s;
   logic             drop1_s;
   logic [MXHS-1:0]  bsy_nxt_s;
   logic [2:0]       nslot_nxt_s;
   logic [8:0]       ovf_sum_s;
   logic [7:0]       ovf_cnt_nxt_s;
   logic [MXHS-1:0]  bsy_hs_r;
   logic [2:0]       nslot_busy_r;
   logic             all_busy_r;
   logic             ovf_r;
   logic [7:0]       ovf_cnt_r;

   // A slot expiring this clock is reusable; the new load overrides the expiry.
   assign free_s = ~active_s | expiring_s;

   assign cfg0_s = '{lo:   win_lo(9'(clct0_key), cfg_width, TOP_KEY),
                     hi:   win_hi(9'(clct0_key), cfg_width, TOP_KEY),
                     hold: cfg_hold};
   assign cfg1_s = '{lo:   win_lo(9'(clct1_key), cfg_width, TOP_KEY),
                     hi:   win_hi(9'(clct1_key), cfg_width, TOP_KEY),
                     hold: cfg_hold};

   // Slot allocation: clct0 takes the lowest free slot, clct1 the next one.
   always_comb begin
      alloc_ok_s = cfg_en && (cfg_hold != 4'd0) && !flush;
      req0_s     = alloc_ok_s && clct0_vld;
      req1_s     = alloc_ok_s && clct1_vld;
      load_s     = '0;
      taken0_s   = 1'b0;
      taken1_s   = 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
         load_cfg_s[i] = cfg0_s;
         if (free_s[i] && req0_s && !taken0_s) begin
            load_s[i] = 1'b1;
            taken0_s  = 1'b1;
         end else if (free_s[i] && req1_s && !taken1_s) begin
            load_s[i]     = 1'b1;
            load_cfg_s[i] = cfg1_s;
            taken1_s      = 1'b1;
         end else begin
            load_s[i] = 1'b0;
         end
      end
      drop0_s = req0_s && !taken0_s;
      drop1_s = req1_s && !taken1_s;
   end

   for (genvar g = 0; g < NSLOT; g++) begin : g_slot
      busy_window_slot #(
         .MXHS(MXHS)
      ) u_slot (
         .clock      (clock),
         .reset_n    (reset_n),
         .flush      (flush),
         .load       (load_s[g]),
         .load_cfg   (load_cfg_s[g]),
         .active     (active_s[g]),
         .expiring   (expiring_s[g]),
         .active_nxt (active_nxt_s[g]),
         .mask       (mask_s[g])
      );
   end

   // OR-reduce the slot masks and count the slots that stay active.
   always_comb begin
      bsy_nxt_s   = '0;
      nslot_nxt_s = 3'd0;
      for (int i = 0; i < NSLOT; i++) begin
         bsy_nxt_s   = bsy_nxt_s | mask_s[i];
         nslot_nxt_s = nslot_nxt_s + 3'(active_nxt_s[i]);
      end
   end

   // Saturating drop counter; two drops in one clock add two.
   always_comb begin
      ovf_sum_s = {1'b0, ovf_cnt_r} + 9'(drop0_s) + 9'(drop1_s);
      if (ovf_sum_s > 9'd255) begin
         ovf_cnt_nxt_s = 8'd255;
      end else begin
         ovf_cnt_nxt_s = ovf_sum_s[7:0];
      end
   end

   // Registered status outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bsy_hs_r     <= '0;
         nslot_busy_r <= 3'd0;
         all_busy_r   <= 1'b0;
         ovf_r        <= 1'b0;
         ovf_cnt_r    <= 8'd0;
      end else begin
         bsy_hs_r     <= bsy_nxt_s;
         nslot_busy_r <= nslot_nxt_s;
         all_busy_r   <= (nslot_nxt_s == 3'(NSLOT));
         ovf_r        <= drop0_s || drop1_s;
         ovf_cnt_r    <= ovf_cnt_nxt_s;
      end
   end

   assign bsy_hs     = bsy_hs_r;
   assign nslot_busy = nslot_busy_r;
   assign all_busy   = all_busy_r;
   assign ovf        = ovf_r;
   assign ovf_cnt    = ovf_cnt_r;

endmodule

// File: doc/busy_window_scheduler.md
BUSY_WINDOW_SCHEDULER -- requirements
Module: busy_window_scheduler

Interface
REQ-001 Parameter MXHS, default 224: number of 1/2-strip keys covered; MXHS SHALL be at most 256.
REQ-002 Parameter MXKEYBX, default 8: width of the 1/2-strip key field.
REQ-003 Parameter NSLOT, default 4: number of concurrent busy windows.
REQ-004 Port clock, input, 1: the block's single clock; all state SHALL change on its rising edge.
REQ-005 Port reset_n, input, 1: asynchronous active-low reset.
REQ-006 Port cfg_en, input, 1: 1 = scheduler enabled; 0 = no allocation.
REQ-007 Port cfg_width, input, 5: half-width of the busy window in 1/2-strips.
REQ-008 Port cfg_hold, input, 4: busy duration in clocks; 0 = no allocation.
REQ-009 Port flush, input, 1: synchronous clear of all slots.
REQ-010 Port clct0_vld, input, 1: first best-pattern candidate valid.
REQ-011 Port clct0_key, input, MXKEYBX: key of the first candidate.
REQ-012 Port clct1_vld, input, 1: second best-pattern candidate valid.
REQ-013 Port clct1_key, input, MXKEYBX: key of the second candidate.
REQ-014 Port bsy_hs, output, MXHS: per-key busy flags feeding the pattern sorter bsy inputs.
REQ-015 Port nslot_busy, output, 3: count of active slots.
REQ-016 Port all_busy, output, 1: all NSLOT slots active.
REQ-017 Port ovf, output, 1: one-clock pulse when a request is dropped.
REQ-018 Port ovf_cnt, output, 8: saturating count of dropped requests.

Function
REQ-019 Each slot SHALL hold: active bit, lo key, hi key, and a 4-bit countdown.
REQ-020 Allocation SHALL occur when cfg_en=1, cfg_hold!=0, flush=0, and the candidate vld=1.
REQ-021 On allocation, the slot SHALL store lo = max(key - cfg_width, 0) and hi = min(key + cfg_width, MXHS-1), using 9-bit signed-safe arithmetic, and countdown = cfg_hold.
REQ-022 Bounds and hold SHALL be latched at allocation; later cfg changes SHALL NOT alter active slots.
REQ-023 A key >= MXHS SHALL be clamped to lo/hi within 0..MXHS-1 and SHALL NOT raise ovf.
REQ-024 Each active slot SHALL decrement its countdown every clock; a slot whose countdown is 1 SHALL become inactive on the next edge.
REQ-025 A slot with countdown = 1 in the current cycle SHALL count as free for allocation in that cycle (the new load overrides expiry).
REQ-026 clct0 SHALL take the lowest-index free slot and clct1 the next-lowest.
REQ-027 When only one slot is free and both candidates are valid, clct0 SHALL win; clct1 SHALL be dropped.
REQ-028 Each dropped request SHALL assert ovf for one clock and increment ovf_cnt by one (two drops in one clock = +2), saturating at 255.
REQ-029 Requests with key inside an existing window SHALL still allocate; the block SHALL apply no overlap suppression.
REQ-030 bsy_hs[k] SHALL be registered: 1 iff some active slot has lo <= k <= hi; it SHALL first assert the clock after the allocating edge (latency 1).
REQ-031 A window of hold H SHALL keep bsy_hs asserted for exactly H consecutive clocks.
REQ-032 flush=1 SHALL deactivate all slots at the next edge, clear bsy_hs one clock later, ignore same-cycle requests without counting them as ovf, and leave ovf_cnt unchanged.
REQ-033 cfg_en=0 SHALL block new allocations while existing slots expire normally.
REQ-034 nslot_busy and all_busy SHALL be registered, reflecting slot state after each edge.

Reset
REQ-035 reset_n=0 SHALL asynchronously clear all slots, bsy_hs, nslot_busy, all_busy, ovf, and ovf_cnt to 0.
REQ-036 Deassertion SHALL take effect at the first edge after release; requests during reset SHALL be lost and not counted.

Structure
REQ-037 MXHS, MXKEYBX, and NSLOT defaults SHALL live in the shared pattern parameters include.
REQ-038 One sub-module, busy_window_slot (one slot: state, countdown, range compare producing an MXHS-bit mask), SHALL be instantiated NSLOT times; allocation and OR-reduction SHALL remain in the top module.

Verification
REQ-039 Scenario: width=2, hold=3, clct0 key=10 -> bsy_hs[12:8]=1 for exactly 3 clocks starting 1 clock after; nslot_busy 1 -> 0.
REQ-040 Scenario: width=4, keys 1 and 222 in the same clock -> bsy_hs[5:0] and bsy_hs[223:218] set; no wrap; nslot_busy=2.
REQ-041 Scenario: hold=15, 4 single requests, then a fifth -> ovf pulses once, ovf_cnt=1, all_busy=1, and no new bits are set.
REQ-042 Scenario: 3 slots full, both vld -> clct0 allocated, clct1 dropped, ovf_cnt+1; a slot at countdown=1 is reused in the same cycle.
REQ-043 Scenario: flush mid-hold with a simultaneous request -> all bsy_hs clear after 2 clocks, ovf_cnt unchanged.
REQ-044 Scenario: reset_n asserted mid-hold, asynchronously between edges -> outputs 0 immediately; after release, hold=2 key=100 behaves as in REQ-039.
